tile_writer_mc: RTL
===================

Name: tile_writer_mc

Overview:
- Multi-channel, lane-parallel successor to the single-channel tile writer.
- Takes a stream of output-tile beats from the compute array. Each beat carries LANES channels of one pixel.
- Writes the beats to a channel-interleaved (HWC) feature map in memory through a valid/ready write port with backpressure.
- Adds partial-group byte strobes, zero-size tile handling and optional image-edge clipping.

Parameters:
- DATA_W, 8, bits per channel element
- LANES, 4, channels carried per beat (power of two ≥1)
- ADDR_W, 32, element address width
- DIM_W, 16, width of dimension/channel config fields

Ports:
- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- start  in  1  begin tile; accepted only when busy=0
- cfg_img_h  in  DIM_W  image height (rows)
- cfg_img_w  in  DIM_W  image width (cols)
- cfg_channels  in  DIM_W  channels C
- cfg_base_addr  in  ADDR_W  element address of pixel (0,0) ch 0
- cfg_tile_out_row  in  DIM_W  tile origin row
- cfg_tile_out_col  in  DIM_W  tile origin col
- cfg_tile_out_h  in  DIM_W  tile rows
- cfg_tile_out_w  in  DIM_W  tile cols
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid&&in_ready
- in_data  in  LANES*DATA_W  lane k = channel g*LANES+k
- wr_valid  out  1  write request valid
- wr_ready  in  1  memory accepts request
- wr_addr  out  ADDR_W  element address of lane 0
- wr_data  out  LANES*DATA_W  write data
- wr_strb  out  LANES  per-lane write enable
- busy  out  1  tile in progress
- done  out  1  one-cycle pulse, tile complete

Behaviour:
- Reset values: busy=0, done=0, wr_valid=0, wr_addr=0, wr_data=0, wr_strb=0. All counters and config registers are cleared. Reset mid-tile abandons the tile and drops any pending write.
- Config is registered on an accepted start. start while busy=1 is ignored.
- G = ceil(C/LANES) channel groups.
- Beat order: group innermost, then col, then row. Tile beat count = h*w*G.
- States:
  - IDLE: start → RUN. If h, w or C is 0, go to FLUSH instead; no beats are consumed and no writes are issued.
  - RUN: consumes beats.
  - FLUSH: waits for the output register to empty, pulses done, returns to IDLE.
- in_ready = (state==RUN) && (!wr_valid || wr_ready). in_ready is 0 in the start cycle; the first beat can be accepted the cycle after start.
- One-entry output register:
  - A beat accepted in cycle N presents wr_valid in cycle N+1.
  - wr_* fields hold stable while wr_valid && !wr_ready.
  - Full throughput of 1 beat/cycle when wr_ready=1.
- Address: wr_addr = base + ((tile_row+r)*img_w + (tile_col+c))*C + g*LANES. Computed in ADDR_W bits, modulo 2^ADDR_W.
- Strobe: lane k is enabled iff g*LANES+k < C. Only the final group can be partial.
- Counters g, c, r advance on each accepted beat. At the last beat (r=h-1, c=w-1, g=G-1) all counters wrap to 0 and the FSM moves to FLUSH.
- done is high for exactly 1 cycle: the cycle after the final write handshake, or 1 cycle after entering FLUSH if no write is pending. busy drops in the same cycle as done.
- A start arriving in the done cycle is accepted, because busy=0 in that cycle.
- Excess in_valid beats after the last beat are not consumed (in_ready=0).

Optional Feature:
- Macro: TILE_WRITER_MC_EDGE_CLIP_EN.
- Defined:
  - A beat whose pixel has tile_row+r ≥ img_h or tile_col+c ≥ img_w is consumed normally (counters advance) but issues no write. wr_valid stays 0 for that beat.
  - done still fires at tile end.
- Undefined: every beat is written regardless of image bounds, with the address formula unchanged.

Test Plan:
- Basic tile: LANES=4, C=8, img 8x8, tile (2,3) 2x2, base 0x1000, wr_ready=1.
  - 8 writes.
  - First write addr 0x1000+(2*8+3)*8=0x1098, strb 0xF. Second write 0x109C.
  - Last write addr 0x1000+(3*8+4)*8=0x10E0+4=0x10E4.
  - done 1 cycle after the 8th handshake.
- Partial group: C=6, tile 1x1.
  - 2 writes: strb 0xF, then strb 0x3 at addr base+4.
- Backpressure: hold wr_ready=0 for 5 cycles mid-tile.
  - wr_addr, wr_data and wr_strb stay stable; in_ready=0.
  - No beat is lost or duplicated; total write count is unchanged.
- Zero tile: start with cfg_tile_out_w=0.
  - in_ready is never 1 and no wr_valid.
  - done pulses 2 cycles after start.
- Reset mid-tile: assert rst after 3 of 8 beats.
  - All outputs return to reset values next cycle.
  - A new start then runs a full tile correctly from g=c=r=0.
- Edge clip (macro defined): img 4x4, tile (3,3) 2x2, C=4.
  - 4 beats consumed.
  - Exactly 1 write, addr base+(3*4+3)*4=base+60.
  - done is asserted.

Source files
------------

// File: rtl/tile_writer_mc.sv
// tile_writer_mc: streams LANES-wide channel-group beats of an output tile into an HWC feature map
// Optional image-edge clipping is enabled by defining TILE_WRITER_MC_EDGE_CLIP_EN.
module tile_writer_mc #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DIM_W-1:0]         cfg_img_h,
    input  logic [DIM_W-1:0]         cfg_img_w,
    input  logic [DIM_W-1:0]         cfg_channels,
    input  logic [ADDR_W-1:0]        cfg_base_addr,
    input  logic [DIM_W-1:0]         cfg_tile_out_row,
    input  logic [DIM_W-1:0]         cfg_tile_out_col,
    input  logic [DIM_W-1:0]         cfg_tile_out_h,
    input  logic [DIM_W-1:0]         cfg_tile_out_w,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*DATA_W-1:0]  in_data,
    output logic                     wr_valid,
    input  logic                     wr_ready,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [LANES*DATA_W-1:0]  wr_data,
    output logic [LANES-1:0]         wr_strb,
    output logic                     busy,
    output logic                     done
);
    localparam int LG = $clog2(LANES);
    localparam int CW = DIM_W + LG + 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                    state_q, state_d;
    logic [DIM_W-1:0]          img_h_q, img_h_d, img_w_q, img_w_d, ch_q, ch_d;
    logic [DIM_W-1:0]          row_q, row_d, col_q, col_d, h_q, h_d, w_q, w_d, ngrp_q, ngrp_d;
    logic [DIM_W-1:0]          g_q, g_d, c_q, c_d, r_q, r_d;
    logic [ADDR_W-1:0]         base_q, base_d, addr_q, addr_d;
    logic [LANES*DATA_W-1:0]   data_q, data_d;
    logic [LANES-1:0]          strb_q, strb_d;
    logic                      wv_q, wv_d, done_q, done_d;
    logic                      accept, clip, last_g, last_c, last_r;
    logic [ADDR_W-1:0]         row_a, col_a, addr_calc;
    logic [LANES-1:0]          strb_calc;
    logic [DIM_W:0]            grp_sum;

    assign in_ready = (state_q == RUN) && (!wv_q || wr_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = state_q != IDLE;
    assign done     = done_q;
    assign wr_valid = wv_q;
    assign wr_addr  = addr_q;
    assign wr_data  = data_q;
    assign wr_strb  = strb_q;
    assign last_g   = g_q == ngrp_q - DIM_W'(1);
    assign last_c   = c_q == w_q - DIM_W'(1);
    assign last_r   = r_q == h_q - DIM_W'(1);
    assign grp_sum  = {1'b0, cfg_channels} + (DIM_W+1)'(LANES - 1);

`ifdef TILE_WRITER_MC_EDGE_CLIP_EN
    assign clip = ({1'b0, row_q} + {1'b0, r_q} >= {1'b0, img_h_q}) ||
                  ({1'b0, col_q} + {1'b0, c_q} >= {1'b0, img_w_q});
`else
    logic unused_img_h;
    assign clip         = 1'b0;
    assign unused_img_h = ^img_h_q;
`endif

    // Element address and lane strobes of the beat at the current (r, c, g) position
    always_comb begin
        row_a     = ADDR_W'(row_q) + ADDR_W'(r_q);
        col_a     = ADDR_W'(col_q) + ADDR_W'(c_q);
        addr_calc = base_q + (row_a * ADDR_W'(img_w_q) + col_a) * ADDR_W'(ch_q) + (ADDR_W'(g_q) << LG);
        for (int k = 0; k < LANES; k++)
            strb_calc[k] = ((CW'(g_q) << LG) + CW'(k)) < CW'(ch_q);
    end

    // Next-state: config capture, beat counters, output register and done pulse
    always_comb begin
        state_d = state_q;
        img_h_d = img_h_q;
        img_w_d = img_w_q;
        ch_d    = ch_q;
        row_d   = row_q;
        col_d   = col_q;
        h_d     = h_q;
        w_d     = w_q;
        ngrp_d  = ngrp_q;
        base_d  = base_q;
        g_d     = g_q;
        c_d     = c_q;
        r_d     = r_q;
        wv_d    = wv_q && !wr_ready;
        addr_d  = addr_q;
        data_d  = data_q;
        strb_d  = strb_q;
        done_d  = 1'b0;
        if (state_q == IDLE && start) begin
            img_h_d = cfg_img_h;
            img_w_d = cfg_img_w;
            ch_d    = cfg_channels;
            row_d   = cfg_tile_out_row;
            col_d   = cfg_tile_out_col;
            h_d     = cfg_tile_out_h;
            w_d     = cfg_tile_out_w;
            base_d  = cfg_base_addr;
            ngrp_d  = DIM_W'(grp_sum >> LG);
            g_d     = '0;
            c_d     = '0;
            r_d     = '0;
            state_d = (cfg_tile_out_h == '0 || cfg_tile_out_w == '0 || cfg_channels == '0) ? FLUSH : RUN;
        end
        if (accept) begin
            wv_d   = !clip;
            addr_d = clip ? addr_q : addr_calc;
            data_d = clip ? data_q : in_data;
            strb_d = clip ? strb_q : strb_calc;
            g_d    = last_g ? '0 : g_q + DIM_W'(1);
            c_d    = last_g ? (last_c ? '0 : c_q + DIM_W'(1)) : c_q;
            r_d    = (last_g && last_c) ? (last_r ? '0 : r_q + DIM_W'(1)) : r_q;
            if (last_g && last_c && last_r)
                state_d = FLUSH;
        end
        if (state_q == FLUSH && (!wv_q || wr_ready)) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
    end

    // Register all state; reset abandons any tile and drops a pending write
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            img_h_q <= '0;
            img_w_q <= '0;
            ch_q    <= '0;
            row_q   <= '0;
            col_q   <= '0;
            h_q     <= '0;
            w_q     <= '0;
            ngrp_q  <= '0;
            base_q  <= '0;
            g_q     <= '0;
            c_q     <= '0;
            r_q     <= '0;
            wv_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            img_h_q <= img_h_d;
            img_w_q <= img_w_d;
            ch_q    <= ch_d;
            row_q   <= row_d;
            col_q   <= col_d;
            h_q     <= h_d;
            w_q     <= w_d;
            ngrp_q  <= ngrp_d;
            base_q  <= base_d;
            g_q     <= g_d;
            c_q     <= c_d;
            r_q     <= r_d;
            wv_q    <= wv_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            done_q  <= done_d;
        end
    end
endmodule
